uart_port_bridge: RTL and testbench

- Parametrised command decoder between a byte UART and the register ports of the wind-sensor datapath.
- Receives write and read commands as bytes, drives NPORTS output registers, and returns snapshots of NPORTS input ports MSB-first.
- Generalises the fixed 16-port, 32-bit scheme: configurable port count and word width, inter-byte timeout, per-port strobes and error reporting.
- The UART itself stays outside the block.

---
 rtl/uart_port_pkg.sv | 23 ++
 rtl/port_bank.sv | 79 +++++++
 rtl/uart_port_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_uart_port_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_port_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the UART port bridge.
package uart_port_pkg;

  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_READ  = 4'h3;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrCommit,
    StRdCapture,
    StRdSend,
    StRdWait
  } state_e;

  // Byte counter only has to reach NB-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned dwidth);
    int unsigned nb;
    nb = dwidth / 8;
    return (nb < 2) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/port_bank.sv
// NPORTS x DWIDTH output register file with write strobes, plus input read mux and read strobes.
module port_bank #(
  parameter int unsigned NPORTS = 16,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [3:0]               wr_port_i,
  input  logic [DWIDTH-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  input  logic [3:0]               rd_port_i,
  output logic [DWIDTH-1:0]        rd_data_o,
  output logic [NPORTS*DWIDTH-1:0] ports_o,
  output logic [NPORTS-1:0]        wstb_o,
  input  logic [NPORTS*DWIDTH-1:0] ports_i,
  output logic [NPORTS-1:0]        rstb_o
);

  logic [DWIDTH-1:0] regs_q [NPORTS];
  logic [DWIDTH-1:0] regs_d [NPORTS];
  logic [NPORTS-1:0] wstb_q, wstb_d;
  logic [NPORTS-1:0] rstb_q, rstb_d;

  // Write-enable and strobe decode; out-of-range ports match nothing.
  always_comb begin
    regs_d = regs_q;
    wstb_d = '0;
    rstb_d = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (wr_en_i && (wr_port_i == 4'(p))) begin
        regs_d[p] = wr_data_i;
        wstb_d[p] = 1'b1;
      end
      if (rd_en_i && (rd_port_i == 4'(p))) begin
        rstb_d[p] = 1'b1;
      end
    end
  end

  // Read mux returns zero for ports that do not exist.
  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (rd_port_i == 4'(p)) begin
        rd_data_o = ports_i[p*DWIDTH +: DWIDTH];
      end
    end
  end

  // Pack the register file onto the flat output bus.
  always_comb begin
    ports_o = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      ports_o[p*DWIDTH +: DWIDTH] = regs_q[p];
    end
  end

  // Register file and strobes; strobes appear with the value they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        regs_q[p] <= '0;
      end
      wstb_q <= '0;
      rstb_q <= '0;
    end else begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        regs_q[p] <= regs_d[p];
      end
      wstb_q <= wstb_d;
      rstb_q <= rstb_d;
    end
  end

  assign wstb_o = wstb_q;
  assign rstb_o = rstb_q;

endmodule

// File: rtl/uart_port_bridge.sv
// Byte-command decoder bridging a UART to NPORTS output registers and NPORTS input ports.
module uart_port_bridge
  import uart_port_pkg::*;
#(
  parameter int unsigned NPORTS      = 16,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     tx_ready,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic [NPORTS*DWIDTH-1:0] out_ports,
  output logic [NPORTS-1:0]        out_wstb,
  input  logic [NPORTS*DWIDTH-1:0] in_ports,
  output logic [NPORTS-1:0]        in_rstb,
  output logic                     frame_err
);

  localparam int unsigned NB = DWIDTH / 8;
  localparam int unsigned CW = cnt_width(DWIDTH);

  state_e            state_q, state_d;
  logic [3:0]        port_q, port_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] wr_shift_q, wr_shift_d;
  logic [DWIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              skip_q, skip_d;
  logic              ferr_q, ferr_d;
  logic              pend_q, pend_d;

  logic              port_ok;
  logic              cnt_last;
  logic [DWIDTH-1:0] wr_word;
  logic              wr_en;
  logic              rd_en;
  logic [DWIDTH-1:0] rd_data;
  logic              err;
  logic              stray;
  logic              busy;

  assign port_ok  = (32'(port_q) < NPORTS);
  assign cnt_last = (cnt_q == CW'(NB - 1));
  // Truncating cast keeps the low DWIDTH bits: old word shifted up, new byte at the bottom.
  assign wr_word  = DWIDTH'({wr_shift_q, rx_data});
  assign tx_data  = tx_shift_q[DWIDTH-1 -: 8];

  port_bank #(
    .NPORTS (NPORTS),
    .DWIDTH (DWIDTH)
  ) u_port_bank (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .wr_en_i   (wr_en),
    .wr_port_i (port_q),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_en),
    .rd_port_i (port_q),
    .rd_data_o (rd_data),
    .ports_o   (out_ports),
    .wstb_o    (out_wstb),
    .ports_i   (in_ports),
    .rstb_o    (in_rstb)
  );

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    wr_shift_d = wr_shift_q;
    tx_shift_d = tx_shift_q;
    tmo_d      = '0;
    skip_d     = 1'b0;
    err        = 1'b0;
    stray      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    tx_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_ready) begin
          if (rx_data[7:4] == OP_WRITE) begin
            state_d = StWrData;
            port_d  = rx_data[3:0];
            cnt_d   = '0;
          end else if (rx_data[7:4] == OP_READ) begin
            state_d = StRdCapture;
            port_d  = rx_data[3:0];
            cnt_d   = '0;
          end else begin
            err = 1'b1;
          end
        end
      end
      StWrData: begin
        if (rx_ready) begin
          // A byte arriving on the expiry cycle still counts and restarts the timer.
          wr_shift_d = wr_word;
          if (cnt_last) begin
            // Commit on the last byte's edge so the word is visible during StWrCommit.
            state_d = StWrCommit;
            if (port_ok) begin
              wr_en = 1'b1;
            end else begin
              err = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (tmo_q == TIMEOUT_CYC - 1) begin
            err     = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end
      StWrCommit: begin
        state_d = StIdle;
      end
      StRdCapture: begin
        rd_en      = port_ok;
        tx_shift_d = rd_data;
        err        = !port_ok;
        state_d    = StRdSend;
      end
      StRdSend: begin
        if (tx_ready) begin
          tx_en   = 1'b1;
          skip_d  = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        // First cycle after tx_en ignores tx_ready while the transmitter drops it.
        if (!skip_q && tx_ready) begin
          tx_shift_d = tx_shift_q << 8;
          if (cnt_last) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StRdSend;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rx_ready && (state_q != StIdle) && (state_q != StWrData)) begin
      stray = 1'b1;
    end
  end

  // A strobe fires next cycle; hold any error back one cycle so pulses never overlap.
  always_comb begin
    busy = wr_en | rd_en;
    if (busy) begin
      ferr_d = 1'b0;
      pend_d = err | stray | pend_q;
    end else begin
      ferr_d = err | stray | pend_q;
      pend_d = (err & stray) | ((err | stray) & pend_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      port_q     <= '0;
      cnt_q      <= '0;
      wr_shift_q <= '0;
      tx_shift_q <= '0;
      tmo_q      <= '0;
      skip_q     <= 1'b0;
      ferr_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      wr_shift_q <= wr_shift_d;
      tx_shift_q <= tx_shift_d;
      tmo_q      <= tmo_d;
      skip_q     <= skip_d;
      ferr_q     <= ferr_d;
      pend_q     <= pend_d;
    end
  end

  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_port_bridge.sv
// Directed bench for uart_port_bridge: three configurations sharing one clock and byte stream.
module tb_uart_port_bridge;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  int         sel = 0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Config A: 16 x 32, timeout 100
  logic         rx_ready_a, tx_en_a, frame_err_a;
  logic [7:0]   tx_data_a;
  logic [511:0] out_ports_a, in_ports_a;
  logic [15:0]  out_wstb_a, in_rstb_a;
  // Config B: 4 x 32, no timeout
  logic         rx_ready_b, tx_en_b, frame_err_b;
  logic [7:0]   tx_data_b;
  logic [127:0] out_ports_b, in_ports_b;
  logic [3:0]   out_wstb_b, in_rstb_b;
  // Config C: 8 x 16, loop-back
  logic         rx_ready_c, tx_en_c, frame_err_c;
  logic [7:0]   tx_data_c;
  logic [127:0] out_ports_c, in_ports_c;
  logic [7:0]   out_wstb_c, in_rstb_c;

  assign rx_ready_a = rx_ready && (sel == 0);
  assign rx_ready_b = rx_ready && (sel == 1);
  assign rx_ready_c = rx_ready && (sel == 2);
  assign in_ports_c = out_ports_c;

  logic       tx_en_sel;
  logic [7:0] tx_data_sel;
  assign tx_en_sel   = (sel == 0) ? tx_en_a : (sel == 1) ? tx_en_b : tx_en_c;
  assign tx_data_sel = (sel == 0) ? tx_data_a : (sel == 1) ? tx_data_b : tx_data_c;

  uart_port_bridge #(.NPORTS(16), .DWIDTH(32), .TIMEOUT_CYC(100)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .rx_ready(rx_ready_a), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_en(tx_en_a), .tx_data(tx_data_a), .out_ports(out_ports_a),
    .out_wstb(out_wstb_a), .in_ports(in_ports_a), .in_rstb(in_rstb_a), .frame_err(frame_err_a)
  );

  uart_port_bridge #(.NPORTS(4), .DWIDTH(32), .TIMEOUT_CYC(0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .rx_ready(rx_ready_b), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_en(tx_en_b), .tx_data(tx_data_b), .out_ports(out_ports_b),
    .out_wstb(out_wstb_b), .in_ports(in_ports_b), .in_rstb(in_rstb_b), .frame_err(frame_err_b)
  );

  uart_port_bridge #(.NPORTS(8), .DWIDTH(16), .TIMEOUT_CYC(0)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .rx_ready(rx_ready_c), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_en(tx_en_c), .tx_data(tx_data_c), .out_ports(out_ports_c),
    .out_wstb(out_wstb_c), .in_ports(in_ports_c), .in_rstb(in_rstb_c), .frame_err(frame_err_c)
  );

  // Pulse counters (values sampled just before each edge updates them).
  int ferr_a = 0, ferr_b = 0, wstb_a = 0, wstb_b = 0, rstb_a = 0, rstb_b = 0, txen_n = 0;
  always @(posedge clock) begin
    if (frame_err_a) ferr_a <= ferr_a + 1;
    if (frame_err_b) ferr_b <= ferr_b + 1;
    if (out_wstb_a != 0) wstb_a <= wstb_a + 1;
    if (out_wstb_b != 0) wstb_b <= wstb_b + 1;
    if (in_rstb_a != 0) rstb_a <= rstb_a + 1;
    if (in_rstb_b != 0) rstb_b <= rstb_b + 1;
    if (tx_en_sel) txen_n <= txen_n + 1;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int s, input logic [7:0] b);
    @(negedge clock);
    sel = s;
    rx_data = b;
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b = 8'h00;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      tx_ready = 1'b1;
      #1;
      if (tx_en_sel) begin
        b = tx_data_sel;
        ok = 1'b1;
      end
    end
    @(negedge clock);
    tx_ready = 1'b0;
    @(negedge clock);
  endtask

  // Reads nb bytes and compares against exp, MSB byte first; finishes the last handshake.
  task automatic read_word(input string tag, input int nb, input logic [31:0] exp);
    logic [7:0] b;
    bit ok;
    int start;
    start = txen_n;
    for (int k = 0; k < nb; k++) begin
      read_byte(b, ok);
      if (!ok) begin
        check({tag, "_timeout"}, 0, 1);
        break;
      end
      check($sformatf("%s_byte%0d", tag, k), b, exp[(nb-1-k)*8 +: 8]);
    end
    @(negedge clock);
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
    @(negedge clock);
    check({tag, "_txen_count"}, txen_n - start, nb);
  endtask

  int f0, w0, r0, n;
  bit found;
  logic [511:0] exp_a;

  initial begin
    in_ports_a = '0;
    in_ports_a[1*32 +: 32] = 32'hFFFF_FFB1;
    in_ports_a[0*32 +: 32] = 32'h1234_5678;
    in_ports_a[2*32 +: 32] = 32'h0BAD_F00D;
    in_ports_b = {4{32'hDEAD_BEEF}};

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_out_ports", out_ports_a, 0);
    check("rst_out_wstb", out_wstb_a, 0);
    check("rst_in_rstb", in_rstb_a, 0);
    check("rst_tx_en", tx_en_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_frame_err", frame_err_a, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Write 14 to port 2
    w0 = wstb_a;
    send_byte(0, 8'h22);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    send_byte(0, 8'h0E);
    #1;
    exp_a = '0;
    exp_a[2*32 +: 32] = 32'd14;
    check("wr2_wstb", out_wstb_a, 16'h0004);
    check("wr2_ports", out_ports_a, exp_a);
    @(negedge clock);
    #1;
    check("wr2_wstb_drop", out_wstb_a, 0);
    check("wr2_wstb_count", wstb_a - w0, 1);

    // Read port 1 -> FF FF FF B1
    r0 = rstb_a;
    send_byte(0, 8'h31);
    @(negedge clock);
    #1;
    check("rd1_rstb", in_rstb_a, 16'h0002);
    read_word("rd1", 4, 32'hFFFF_FFB1);
    check("rd1_rstb_count", rstb_a - r0, 1);

    // Bad opcode
    f0 = ferr_a;
    send_byte(0, 8'h72);
    repeat (2) @(negedge clock);
    check("badop_ferr", ferr_a - f0, 1);
    check("badop_ports", out_ports_a, exp_a);

    // Inter-byte timeout on port 5
    f0 = ferr_a;
    w0 = wstb_a;
    send_byte(0, 8'h25);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 150 && !found; i++) begin
      #1;
      if (frame_err_a) begin
        found = 1'b1;
        n = i;
      end else begin
        @(negedge clock);
      end
    end
    check("tmo_seen", found, 1);
    check("tmo_cycle_in_window", (n >= 100 && n <= 101), 1);
    repeat (50) @(negedge clock);
    check("tmo_ferr_count", ferr_a - f0, 1);
    check("tmo_no_write", wstb_a - w0, 0);
    check("tmo_ports", out_ports_a, exp_a);
    send_byte(0, 8'h25);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    send_byte(0, 8'h33);
    send_byte(0, 8'h44);
    #1;
    exp_a[5*32 +: 32] = 32'h1122_3344;
    check("tmo_rewrite", out_ports_a, exp_a);

    // Config B: write to nonexistent port 9
    f0 = ferr_b;
    w0 = wstb_b;
    send_byte(1, 8'h29);
    send_byte(1, 8'h01);
    send_byte(1, 8'h02);
    send_byte(1, 8'h03);
    send_byte(1, 8'h04);
    repeat (2) @(negedge clock);
    check("b_wr9_ferr", ferr_b - f0, 1);
    check("b_wr9_wstb", wstb_b - w0, 0);
    check("b_wr9_ports", out_ports_b, 0);

    // Config B: read port 9 returns zeros, no read strobe
    f0 = ferr_b;
    r0 = rstb_b;
    send_byte(1, 8'h39);
    read_word("b_rd9", 4, 32'h0000_0000);
    check("b_rd9_ferr", ferr_b - f0, 1);
    check("b_rd9_rstb", rstb_b - r0, 0);

    // Config B: frame after the bad write decodes as a command
    send_byte(1, 8'h32);
    read_word("b_rd2", 4, 32'hDEAD_BEEF);

    // Reset in the middle of a write to port 3
    send_byte(0, 8'h23);
    send_byte(0, 8'hA5);
    send_byte(0, 8'hA5);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ports", out_ports_a, 0);
    check("mid_rst_ferr", frame_err_a, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    send_byte(0, 8'h23);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    send_byte(0, 8'h33);
    send_byte(0, 8'h44);
    #1;
    exp_a = '0;
    exp_a[3*32 +: 32] = 32'h1122_3344;
    check("post_rst_write", out_ports_a, exp_a);
    check("post_rst_wstb", out_wstb_a, 16'h0008);

    // Config C: 16-bit words, loop-back read
    send_byte(2, 8'h27);
    send_byte(2, 8'hBE);
    send_byte(2, 8'hEF);
    #1;
    check("c_wr7_port", out_ports_c[7*16 +: 16], 16'hBEEF);
    check("c_wr7_wstb", out_wstb_c, 8'h80);
    send_byte(2, 8'h37);
    read_word("c_rd7", 2, 32'h0000_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
